cfg_stream_loader: RTL and testbench
====================================

Name: cfg_stream_loader

Overview:
- Synthesizable fabric-side receiver for the FPGA configuration load protocol.
- Accepts the bitstream as a narrow valid/ready beat stream from an on-chip host, SPI bridge or ROM reader.
- Assembles each stream into one WORD_W-bit configuration word and writes it into the fabric through configs_in plus a one-hot configs_en strobe.
- After the final word it waits a settle period, then raises ff_en and rdy, replacing the file-driven load sequence used in simulation.

Parameters:
- WORD_W, 320: width of one configuration word (configs_in).
- NUM_WORDS, 172: number of configuration words; width of configs_en.
- IN_W, 8: stream beat width. WORD_W % IN_W must be 0, otherwise elaboration error.
- SETTLE_CYC, 10: idle cycles between the last word write and ff_en assertion (≥1).

Ports:
- clock  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a load; honoured in IDLE and DONE only.
- abort  in  1  abandon the load; return to IDLE.
- s_data  in  IN_W  bitstream beat.
- s_valid  in  1  beat valid.
- s_ready  out  1  beat accepted when s_valid && s_ready.
- configs_in  out  WORD_W  current configuration word to the fabric.
- configs_en  out  NUM_WORDS  one-hot word-write strobe to the fabric.
- ff_en  out  1  fabric flip-flop enable; high once configuration is complete.
- rdy  out  1  design ready; high one cycle after ff_en.
- busy  out  1  high in ASSEMBLE, WRITE, SETTLE and ENABLE.
- word_idx  out  $clog2(NUM_WORDS)  index of the word being assembled or written.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0, including configs_in, configs_en, ff_en, rdy, s_ready, busy and word_idx. Reset mid-load discards partial data; the fabric keeps whatever it has latched.
- BEATS = WORD_W/IN_W. Beat k of a word lands in configs_in[k*IN_W +: IN_W], LSB beat first. Words arrive in order 0..NUM_WORDS-1.
- IDLE: s_ready=0. start=1 → ASSEMBLE; word_idx=0, beat_cnt=0, configs_in=0, ff_en=0, rdy=0.
- ASSEMBLE:
  - s_ready=1; configs_en=0.
  - Each accepted beat writes its slice and increments beat_cnt.
  - Acceptance with beat_cnt==BEATS-1 → WRITE.
  - s_valid gaps stall with no timeout.
- WRITE (exactly 1 cycle):
  - configs_en = 1<<word_idx; configs_in stable; s_ready=0.
  - word_idx==NUM_WORDS-1 → SETTLE with settle_cnt=0.
  - Otherwise word_idx++, beat_cnt=0 → ASSEMBLE.
- configs_in holds its last value outside ASSEMBLE; it is not cleared between words. Overwritten slices are sufficient.
- SETTLE: counts SETTLE_CYC cycles with all strobes 0, then → ENABLE.
- ENABLE (1 cycle): ff_en=1 → DONE.
- DONE: ff_en=1, rdy=1, busy=0. start=1 → ASSEMBLE; ff_en and rdy drop the next cycle (reload).
- Latency:
  - start at cycle t gives s_ready=1 at t+1.
  - Last beat of word i accepted at cycle c gives configs_en[i]=1 at c+1 only, and s_ready again at c+2.
  - Last WRITE at cycle w gives ff_en at w+SETTLE_CYC+1 and rdy at w+SETTLE_CYC+2.
- start during busy is ignored.
- abort has priority over start and over beat acceptance in the same cycle. From any state → IDLE next cycle with ff_en=rdy=0, configs_en=0 and configs_in held.
- configs_en is never multi-hot and never asserted outside WRITE.

Decomposition:
- Package cfg_loader_pkg holds:
  - the state enum {IDLE, ASSEMBLE, WRITE, SETTLE, ENABLE, DONE};
  - default parameter constants (WORD_W, NUM_WORDS, IN_W, SETTLE_CYC);
  - a BEATS helper function.
- One sub-module, cfg_word_assembler: beat counter plus slice writer, with a word_done output. The top module holds the FSM, word index, one-hot strobe and settle counter.

Test Plan (bench params WORD_W=16, IN_W=8, NUM_WORDS=4, SETTLE_CYC=3):
- Full load, no gaps. Stimulus: start, then beats 0x11,0x22,...,0x88. Required: configs_en pulses 0001,0010,0100,1000 with configs_in 0x2211, 0x4433, 0x6655, 0x8877 during the respective pulses; ff_en 4 cycles after the last pulse; rdy 1 cycle after ff_en.
- Back-pressure gaps: s_valid toggling randomly. Required: identical words and strobes, with each strobe exactly 1 cycle long.
- abort after word 1's first beat. Required: IDLE next cycle, configs_en=0, ff_en=0. A new start then reloads from word 0.
- Async reset asserted mid-ASSEMBLE of word 2, asynchronous to clock. Required: all outputs 0 immediately; s_ready=0 until start after reset release.
- Reload from DONE. Stimulus: start while rdy=1. Required: ff_en=rdy=0 next cycle; a second load with pattern 0xA5 completes.
- start pulsed while busy, and start+abort in the same cycle. Required: ignored mid-load; abort wins and the block stays IDLE.

Source files
------------

// File: rtl/cfg_loader_pkg.sv
// cfg_loader_pkg: shared state encoding, default sizes and beat-count helper for the config loader
package cfg_loader_pkg;
  localparam int DEF_WORD_W     = 320;
  localparam int DEF_NUM_WORDS  = 172;
  localparam int DEF_IN_W       = 8;
  localparam int DEF_SETTLE_CYC = 10;
  typedef enum logic [2:0] {IDLE, ASSEMBLE, WRITE, SETTLE, ENABLE, DONE} state_t;
  function automatic int beats(input int word_w, input int in_w);
    return word_w / in_w;
  endfunction
endpackage

// File: rtl/cfg_word_assembler.sv
// cfg_word_assembler: packs LSB-first stream beats into one configuration word
module cfg_word_assembler
  import cfg_loader_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int IN_W   = DEF_IN_W
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_accept,
  input  logic [IN_W-1:0]   i_data,
  output logic [WORD_W-1:0] o_word,
  output logic              o_word_done
);
  localparam int BEATS = beats(WORD_W, IN_W);
  localparam int CW    = BEATS > 1 ? $clog2(BEATS) : 1;
  if (WORD_W % IN_W != 0) begin : g_bad_width
    $error("cfg_word_assembler: WORD_W must be a multiple of IN_W");
  end
  logic [CW-1:0]     r_cnt;
  logic [WORD_W-1:0] r_word;
  assign o_word      = r_word;
  assign o_word_done = i_accept && (r_cnt == CW'(BEATS - 1));
  // beat counter wraps after the last beat so the next word starts at slice 0
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else if (i_clear) r_cnt <= '0;
    else if (i_accept) r_cnt <= o_word_done ? '0 : r_cnt + CW'(1);
  end
  // each accepted beat overwrites its own slice; the word is otherwise held
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) r_word <= '0;
    else if (i_clear) r_word <= '0;
    else if (i_accept)
      for (int k = 0; k < BEATS; k++)
        if (r_cnt == CW'(k)) r_word[k*IN_W +: IN_W] <= i_data;
  end
endmodule

// File: rtl/cfg_stream_loader.sv
// cfg_stream_loader: receives a beat stream, writes configuration words, then enables the fabric
module cfg_stream_loader
  import cfg_loader_pkg::*;
#(
  parameter int WORD_W     = DEF_WORD_W,
  parameter int NUM_WORDS  = DEF_NUM_WORDS,
  parameter int IN_W       = DEF_IN_W,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic                         clock,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic [IN_W-1:0]              s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic [WORD_W-1:0]            configs_in,
  output logic [NUM_WORDS-1:0]         configs_en,
  output logic                         ff_en,
  output logic                         rdy,
  output logic                         busy,
  output logic [$clog2(NUM_WORDS)-1:0] word_idx
);
  localparam int IW = $clog2(NUM_WORDS);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  if (SETTLE_CYC < 1) begin : g_bad_settle
    $error("cfg_stream_loader: SETTLE_CYC must be at least 1");
  end
  state_t        r_state, w_next;
  logic [IW-1:0] r_word_idx;
  logic [SW-1:0] r_settle;
  logic          w_go, w_accept, w_word_done, w_last;
  assign w_go     = start && !abort && (r_state == IDLE || r_state == DONE);
  assign w_accept = s_valid && s_ready && !abort;
  assign w_last   = r_word_idx == IW'(NUM_WORDS - 1);
  assign s_ready    = r_state == ASSEMBLE;
  assign busy       = r_state == ASSEMBLE || r_state == WRITE || r_state == SETTLE || r_state == ENABLE;
  assign ff_en      = r_state == ENABLE || r_state == DONE;
  assign rdy        = r_state == DONE;
  assign configs_en = (r_state == WRITE) ? (NUM_WORDS'(1) << r_word_idx) : '0;
  assign word_idx   = r_word_idx;
  cfg_word_assembler #(.WORD_W(WORD_W), .IN_W(IN_W)) u_asm (
    .clock       (clock),
    .rst_n       (rst_n),
    .i_clear     (w_go),
    .i_accept    (w_accept),
    .i_data      (s_data),
    .o_word      (configs_in),
    .o_word_done (w_word_done)
  );
  // state register
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  // next-state logic; abort overrides everything, start only counts when not busy
  always_comb begin
    w_next = r_state;
    if (abort) w_next = IDLE;
    else
      case (r_state)
        IDLE, DONE: if (start) w_next = ASSEMBLE;
        ASSEMBLE:   if (w_word_done) w_next = WRITE;
        WRITE:      w_next = w_last ? SETTLE : ASSEMBLE;
        SETTLE:     if (r_settle == SW'(SETTLE_CYC - 1)) w_next = ENABLE;
        ENABLE:     w_next = DONE;
        default:    w_next = IDLE;
      endcase
  end
  // word index restarts on a new load and advances after each non-final write
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) r_word_idx <= '0;
    else if (w_go) r_word_idx <= '0;
    else if (r_state == WRITE && !abort && !w_last) r_word_idx <= r_word_idx + IW'(1);
  end
  // settle counter runs from the last write until the fabric is enabled
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) r_settle <= '0;
    else if (r_state == WRITE) r_settle <= '0;
    else if (r_state == SETTLE) r_settle <= r_settle + SW'(1);
  end
endmodule

// File: tb/tb_cfg_stream_loader.sv
// tb_cfg_stream_loader: directed checks of load, gaps, abort, reset and reload behaviour
module tb_cfg_stream_loader;
  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] configs_in;
  logic [3:0]  configs_en;
  logic        ff_en, rdy, busy;
  logic [1:0]  word_idx;
  int total = 0;
  int bad = 0;
  logic [7:0] p1 [8];
  logic [7:0] p2 [8];

  cfg_stream_loader #(.WORD_W(16), .NUM_WORDS(4), .IN_W(8), .SETTLE_CYC(3)) dut (
    .clock(clock), .rst_n(rst_n), .start(start), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .configs_in(configs_in), .configs_en(configs_en),
    .ff_en(ff_en), .rdy(rdy), .busy(busy), .word_idx(word_idx)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready;
    int n = 0;
    while (s_ready !== 1'b1 && n < 50) begin
      tick;
      n++;
    end
    if (n >= 50) chk("ready_timeout", {31'd0, s_ready}, 32'd1);
  endtask

  task automatic send_beat(input logic [7:0] d);
    wait_ready;
    s_valid = 1'b1;
    s_data  = d;
    tick;
    s_valid = 1'b0;
  endtask

  task automatic begin_load;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("start_sready", {31'd0, s_ready}, 32'd1);
    chk("start_ffen", {31'd0, ff_en}, 32'd0);
    chk("start_rdy", {31'd0, rdy}, 32'd0);
    chk("start_clear", {16'd0, configs_in}, 32'd0);
  endtask

  task automatic do_load(input logic [7:0] b [8], input bit gaps, input bit poke);
    for (int w = 0; w < 4; w++) begin
      for (int k = 0; k < 2; k++) begin
        if (gaps) repeat ($urandom_range(0, 2)) tick;
        if (poke && w == 2 && k == 0) start = 1'b1;
        send_beat(b[2*w+k]);
        start = 1'b0;
      end
      chk("wr_en", {28'd0, configs_en}, 32'd1 << w);
      chk("wr_data", {16'd0, configs_in}, {16'd0, b[2*w+1], b[2*w]});
      chk("wr_sready", {31'd0, s_ready}, 32'd0);
      tick;
      chk("wr_pulse_end", {28'd0, configs_en}, 32'd0);
      if (w < 3) chk("re_sready", {31'd0, s_ready}, 32'd1);
    end
    tick;
    tick;
    chk("settle_ffen", {31'd0, ff_en}, 32'd0);
    chk("settle_busy", {31'd0, busy}, 32'd1);
    tick;
    chk("enable_ffen", {31'd0, ff_en}, 32'd1);
    chk("enable_rdy", {31'd0, rdy}, 32'd0);
    tick;
    chk("done_rdy", {31'd0, rdy}, 32'd1);
    chk("done_ffen", {31'd0, ff_en}, 32'd1);
    chk("done_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {s_ready, configs_en, ff_en, rdy, busy, word_idx, configs_in}, 32'd0);
  endtask

  initial begin
    p1 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    for (int i = 0; i < 8; i++) p2[i] = 8'hA5;
    tick;
    tick;
    chk_zero("reset_outputs");
    rst_n = 1'b1;
    tick;
    chk_zero("idle_outputs");
    begin_load;
    do_load(p1, 1'b0, 1'b0);
    begin_load;
    do_load(p2, 1'b0, 1'b0);
    chk("reload_a5", {16'd0, configs_in}, 32'hA5A5);
    begin_load;
    do_load(p1, 1'b1, 1'b0);
    begin_load;
    do_load(p1, 1'b0, 1'b1);
    begin_load;
    send_beat(8'h11);
    send_beat(8'h22);
    tick;
    send_beat(8'h33);
    chk("abort_pre_idx", {30'd0, word_idx}, 32'd1);
    abort   = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h44;
    tick;
    abort   = 1'b0;
    s_valid = 1'b0;
    chk("abort_sready", {31'd0, s_ready}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_en", {28'd0, configs_en}, 32'd0);
    chk("abort_ffen", {31'd0, ff_en}, 32'd0);
    chk("abort_hold", {16'd0, configs_in}, 32'h2233);
    tick;
    chk("abort_stay", {31'd0, busy}, 32'd0);
    begin_load;
    chk("abort_restart_idx", {30'd0, word_idx}, 32'd0);
    do_load(p1, 1'b0, 1'b0);
    begin_load;
    for (int i = 0; i < 5; i++) send_beat(p1[i]);
    chk("rst_pre_idx", {30'd0, word_idx}, 32'd2);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_reset");
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    chk_zero("post_reset_idle");
    tick;
    chk("post_reset_sready", {31'd0, s_ready}, 32'd0);
    begin_load;
    do_load(p2, 1'b0, 1'b0);
    start = 1'b1;
    abort = 1'b1;
    tick;
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy", {31'd0, busy}, 32'd0);
    chk("sa_sready", {31'd0, s_ready}, 32'd0);
    chk("sa_ffen", {31'd0, ff_en}, 32'd0);
    chk("sa_rdy", {31'd0, rdy}, 32'd0);
    tick;
    chk("sa_stay", {31'd0, s_ready}, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
